mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//   Upstream controller for an 8:1 channel-select mux. Drives the mux select, waits
//   a programmable settle time, then samples the single-bit mux output. It walks all
//   enabled channels and packs the samples into one parallel snapshot, which it
//   delivers downstream over a valid/ready handshake. Single-shot or continuous.
// PARAMETERS
//   N_CH    8  number of mux channels; must satisfy N_CH <= 2**SEL_W
//   SEL_W   3  select width driven to the mux
//   SETTLE  2  cycles sel is held before sampling; must be >= 1
// PORTS
//   clk         in   1       single clock; all state updates on rising edge
//   rst         in   1       asynchronous, active-high reset
//   start       in   1       scan request; sampled only in IDLE
//   continuous  in   1       1 = rescan automatically after each handshake
//   ch_mask     in   N_CH    channel enables; latched at scan start
//   sel         out  SEL_W   registered mux select
//   mux_out     in   1       mux output (combinational from sel)
//   busy        out  1       1 whenever state != IDLE
//   snap_data   out  N_CH    snapshot; bit i = sample of channel i, 0 if disabled
//   snap_valid  out  1       snapshot available
//   snap_ready  in   1       downstream accepts snapshot
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, sel=0, busy=0, snap_valid=0, snap_data=0,
//     mask_q=0, accumulator=0, settle counter=0. A partial scan is discarded.
//   FSM states: IDLE, SETTLE, HOLD.
//   IDLE: sel=0. On start=1: mask_q<=ch_mask, accumulator<=0.
//     mask nonzero -> sel<=lowest enabled index, cnt<=SETTLE-1, go SETTLE.
//     mask zero -> snap_data<=0, snap_valid<=1, go HOLD (1 cycle latency).
//   SETTLE: cnt!=0 -> cnt<=cnt-1. At cnt==0: accumulator[sel]<=mux_out, then
//     next enabled index > sel exists -> sel<=it, cnt<=SETTLE-1, stay;
//     none -> snap_data<=accumulator incl. this sample, snap_valid<=1, sel<=0, go HOLD.
//   Each enabled channel holds sel for exactly SETTLE cycles; disabled channels
//     are skipped without cost. Latency start edge -> snap_valid = popcount(mask)*SETTLE.
//   HOLD: snap_valid=1; snap_data stable while snap_ready=0.
//     valid&&ready: snap_valid<=0; continuous=1 -> relatch ch_mask and start a new
//     scan exactly as from IDLE (no gap cycle); continuous=0 -> go IDLE.
//   start outside IDLE is ignored (no queuing). ch_mask changes mid-scan have no
//     effect until the next relatch. continuous is sampled only at the handshake.
//   sel never exceeds N_CH-1; counter width = clog2(SETTLE) (min 1 bit).
// TESTING
//   1 SETTLE=1, mask=FF, mux inputs=A5, start pulse -> sel 0..7 one per cycle,
//     snap_valid 8 cycles after start edge, snap_data=A5, busy high throughout.
//   2 SETTLE=2, mask=81, inputs=FF -> sel=0 for 2 cycles, sel=7 for 2 cycles,
//     snap_valid after 4 cycles, snap_data=81.
//   3 mask=00, start -> snap_valid after 1 cycle, snap_data=00, sel stays 0.
//   4 snap_ready low 5 cycles in HOLD, start pulsed -> valid/data stable, start
//     ignored; ready high 1 cycle -> single handshake, return IDLE, busy=0.
//   5 continuous=1, ready=1, inputs change A5->3C between scans -> back-to-back
//     snapshots A5 then 3C with no idle cycle; clear continuous -> IDLE after next.
//   6 rst asserted while sel=3 mid-scan -> sel=0, busy=0, snap_valid=0 without
//     waiting for a clock edge; next start runs a full correct scan.

Source files
------------

// File: rtl/mux_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_sequencer_if
//  Purpose  : Bundle of mux-control and snapshot-handshake signals shared by
//             the scan sequencer (master) and its environment (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface mux_scan_sequencer_if #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
);
  logic              start;
  logic              continuous;
  logic [N_CH-1:0]   ch_mask;
  logic [SEL_W-1:0]  sel;
  logic              mux_out;
  logic              busy;
  logic [N_CH-1:0]   snap_data;
  logic              snap_valid;
  logic              snap_ready;

  // Sequencer side: drives the mux select and presents snapshots.
  modport master (
    input  start, continuous, ch_mask, mux_out, snap_ready,
    output sel, busy, snap_data, snap_valid
  );

  // Environment side: requests scans, models the mux, consumes snapshots.
  modport slave (
    output start, continuous, ch_mask, mux_out, snap_ready,
    input  sel, busy, snap_data, snap_valid
  );
endinterface
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_sequencer
//  Purpose  : Steps an 8:1 mux through all enabled channels, holds each select
//             for SETTLE cycles, samples the mux output and delivers the packed
//             snapshot over valid/ready. Single-shot or continuous operation.
//  Revision : 1.0  initial release
// ============================================================================
module mux_scan_sequencer #(
  parameter int N_CH   = 8,
  parameter int SEL_W  = 3,
  parameter int SETTLE = 2
) (
  input  wire                  clk,
  input  wire                  rst,
  mux_scan_sequencer_if.master bus
);

  // A single-cycle settle still needs one counter bit to keep the datapath legal.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t            state;
  logic [N_CH-1:0]   mask_q;
  logic [N_CH-1:0]   acc;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic [N_CH-1:0]   snap_data;
  logic              snap_valid;

  logic [SEL_W:0]    first_hit;   // {found, index} of lowest enabled channel in ch_mask
  logic [SEL_W:0]    next_hit;    // {found, index} of next enabled channel above sel
  logic [N_CH-1:0]   acc_upd;     // accumulator including the sample taken this cycle
  logic              launch;      // a new scan begins on this edge

  assign bus.sel        = sel;
  assign bus.busy       = busy;
  assign bus.snap_data  = snap_data;
  assign bus.snap_valid = snap_valid;

  // Lowest set bit of m at or above index lo; MSB of result flags a hit.
  function automatic logic [SEL_W:0] find_from(input logic [N_CH-1:0] m, input int lo);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if ((i >= lo) && m[i]) begin
        r = {1'b1, SEL_W'(i)};
      end
    end
    return r;
  endfunction

  // Channel search, sample merge and scan-launch decision.
  always_comb begin
    first_hit = find_from(bus.ch_mask, 0);
    next_hit  = find_from(mask_q, int'(sel) + 1);
    acc_upd   = acc;
    acc_upd[sel] = bus.mux_out;
    launch    = ((state == ST_IDLE) && bus.start) ||
                ((state == ST_HOLD) && snap_valid && bus.snap_ready && bus.continuous);
  end

  // Scan FSM with registered select, busy and snapshot outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mask_q     <= '0;
      acc        <= '0;
      cnt        <= '0;
      sel        <= '0;
      busy       <= 1'b0;
      snap_data  <= '0;
      snap_valid <= 1'b0;
    end else if (launch) begin
      // Same entry path from IDLE and from a continuous-mode handshake,
      // so back-to-back scans have no gap cycle.
      mask_q <= bus.ch_mask;
      acc    <= '0;
      busy   <= 1'b1;
      if (first_hit[SEL_W]) begin
        sel        <= first_hit[SEL_W-1:0];
        cnt        <= CNT_RELOAD;
        snap_valid <= 1'b0;
        state      <= ST_SETTLE;
      end else begin
        sel        <= '0;
        snap_data  <= '0;
        snap_valid <= 1'b1;
        state      <= ST_HOLD;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          sel  <= '0;
          busy <= 1'b0;
        end
        ST_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            acc <= acc_upd;
            if (next_hit[SEL_W]) begin
              sel <= next_hit[SEL_W-1:0];
              cnt <= CNT_RELOAD;
            end else begin
              snap_data  <= acc_upd;
              snap_valid <= 1'b1;
              sel        <= '0;
              state      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (snap_valid && bus.snap_ready) begin
            snap_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          sel   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_scan_sequencer
//  Purpose  : Directed, table-driven bench for mux_scan_sequencer. One instance
//             with SETTLE=1, one with SETTLE=2; the mux is modelled as a
//             constant input byte indexed by sel.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] in1 = 8'h00;
  logic [7:0] in2 = 8'h00;

  mux_scan_sequencer_if #(.N_CH(8), .SEL_W(3)) b1 ();
  mux_scan_sequencer_if #(.N_CH(8), .SEL_W(3)) b2 ();

  assign b1.mux_out = in1[b1.sel];
  assign b2.mux_out = in2[b2.sel];

  mux_scan_sequencer #(.N_CH(8), .SEL_W(3), .SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  mux_scan_sequencer #(.N_CH(8), .SEL_W(3), .SETTLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] din;
    logic [7:0] exp_data;
    int         exp_lat;   // edges after the start edge until snap_valid is seen
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-shot scan on the SETTLE=2 instance, then a handshake.
  task automatic run2(input logic [7:0] m, input logic [7:0] din,
                      input logic [7:0] exp_d, input int exp_lat, input string tag);
    int n;
    b2.ch_mask = m;
    in2        = din;
    b2.start   = 1'b1;
    tick();
    b2.start = 1'b0;
    n = 0;
    while (!b2.snap_valid && n < 60) begin
      tick();
      n++;
    end
    chk($sformatf("%s_lat", tag), n, exp_lat);
    chk($sformatf("%s_data", tag), b2.snap_data, exp_d);
    chk($sformatf("%s_busy", tag), b2.busy, 1);
    chk($sformatf("%s_sel0", tag), b2.sel, 0);
    b2.snap_ready = 1'b1;
    tick();
    b2.snap_ready = 1'b0;
    chk($sformatf("%s_valid_clr", tag), b2.snap_valid, 0);
    chk($sformatf("%s_idle", tag), b2.busy, 0);
  endtask

  initial begin
    int n;
    b1.start = 1'b0; b1.continuous = 1'b0; b1.ch_mask = 8'h00; b1.snap_ready = 1'b0;
    b2.start = 1'b0; b2.continuous = 1'b0; b2.ch_mask = 8'h00; b2.snap_ready = 1'b0;

    vecs[0] = '{8'h81, 8'hFF, 8'h81, 4};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 0};
    vecs[2] = '{8'hFF, 8'hA5, 8'hA5, 16};
    vecs[3] = '{8'h0F, 8'hFF, 8'h0F, 8};
    vecs[4] = '{8'h5A, 8'h3C, 8'h18, 8};
    vecs[5] = '{8'h80, 8'h80, 8'h80, 2};
    vecs[6] = '{8'h01, 8'h00, 8'h00, 2};
    vecs[7] = '{8'hF0, 8'h96, 8'h90, 8};

    // Reset state
    tick(); tick();
    chk("rst_sel1", b1.sel, 0);   chk("rst_busy1", b1.busy, 0);
    chk("rst_valid1", b1.snap_valid, 0); chk("rst_data1", b1.snap_data, 0);
    chk("rst_sel2", b2.sel, 0);   chk("rst_busy2", b2.busy, 0);
    chk("rst_valid2", b2.snap_valid, 0); chk("rst_data2", b2.snap_data, 0);
    rst = 1'b0;
    tick();

    // SETTLE=1, full mask: one channel per cycle
    b1.ch_mask = 8'hFF; in1 = 8'hA5; b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    chk("t1_sel_e0", b1.sel, 0);
    chk("t1_busy_e0", b1.busy, 1);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("t1_sel_e%0d", k), b1.sel, k);
      chk($sformatf("t1_novalid_e%0d", k), b1.snap_valid, 0);
      chk($sformatf("t1_busy_e%0d", k), b1.busy, 1);
    end
    tick();
    chk("t1_valid_e8", b1.snap_valid, 1);
    chk("t1_data", b1.snap_data, 8'hA5);
    chk("t1_sel_hold", b1.sel, 0);
    b1.snap_ready = 1'b1;
    tick();
    b1.snap_ready = 1'b0;
    chk("t1_done", b1.busy, 0);

    // SETTLE=2, mask 81: select trace
    b2.ch_mask = 8'h81; in2 = 8'hFF; b2.start = 1'b1;
    tick(); b2.start = 1'b0; chk("t2_sel_e0", b2.sel, 0);
    tick(); chk("t2_sel_e1", b2.sel, 0);
    tick(); chk("t2_sel_e2", b2.sel, 7);
    tick(); chk("t2_sel_e3", b2.sel, 7); chk("t2_novalid_e3", b2.snap_valid, 0);
    tick(); chk("t2_valid_e4", b2.snap_valid, 1); chk("t2_data", b2.snap_data, 8'h81);
    b2.snap_ready = 1'b1; tick(); b2.snap_ready = 1'b0;
    chk("t2_done", b2.busy, 0);

    // Table of single-shot scans
    for (int v = 0; v < 8; v++) begin
      run2(vecs[v].mask, vecs[v].din, vecs[v].exp_data, vecs[v].exp_lat, $sformatf("vec%0d", v));
    end

    // Back-pressure in HOLD; start and mask/input changes ignored
    b2.ch_mask = 8'h03; in2 = 8'h02; b2.start = 1'b1;
    tick(); b2.start = 1'b0;
    n = 0;
    while (!b2.snap_valid && n < 60) begin tick(); n++; end
    chk("t4_lat", n, 4);
    b2.ch_mask = 8'hFF; in2 = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      b2.start = (k == 2);
      tick();
      chk($sformatf("t4_valid_%0d", k), b2.snap_valid, 1);
      chk($sformatf("t4_data_%0d", k), b2.snap_data, 8'h02);
      chk($sformatf("t4_busy_%0d", k), b2.busy, 1);
    end
    b2.start = 1'b0;
    b2.snap_ready = 1'b1; tick(); b2.snap_ready = 1'b0;
    chk("t4_hs_valid", b2.snap_valid, 0); chk("t4_hs_busy", b2.busy, 0);
    tick();
    chk("t4_noqueue_busy", b2.busy, 0); chk("t4_noqueue_valid", b2.snap_valid, 0);

    // Continuous mode: back-to-back snapshots, then stop
    b2.continuous = 1'b1; b2.snap_ready = 1'b1;
    b2.ch_mask = 8'hFF; in2 = 8'hA5; b2.start = 1'b1;
    tick(); b2.start = 1'b0;
    n = 0;
    while (!b2.snap_valid && n < 60) begin tick(); n++; end
    chk("t5_lat1", n, 16); chk("t5_data1", b2.snap_data, 8'hA5);
    in2 = 8'h3C;
    tick();
    chk("t5_gap_valid", b2.snap_valid, 0);
    chk("t5_gap_busy", b2.busy, 1);
    chk("t5_gap_sel", b2.sel, 0);
    b2.continuous = 1'b0;
    n = 0;
    while (!b2.snap_valid && n < 60) begin tick(); n++; end
    chk("t5_lat2", n, 16); chk("t5_data2", b2.snap_data, 8'h3C);
    tick();
    chk("t5_stop_busy", b2.busy, 0); chk("t5_stop_valid", b2.snap_valid, 0);
    b2.snap_ready = 1'b0;

    // Asynchronous reset mid-scan
    b2.ch_mask = 8'hFF; in2 = 8'h00; b2.start = 1'b1;
    tick(); b2.start = 1'b0;
    n = 0;
    while (b2.sel != 3'd3 && n < 40) begin tick(); n++; end
    chk("t6_reach_sel3", b2.sel, 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_sel", b2.sel, 0);
    chk("t6_busy", b2.busy, 0);
    chk("t6_valid", b2.snap_valid, 0);
    #2 rst = 1'b0;
    run2(8'hFF, 8'h5A, 8'h5A, 16, "t6_rescan");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
